// File: rtl/tex_flash_sched.sv
// Purpose : arbitrates two single-byte SPI flash read requesters (renderer, host) onto one flash port.
// Latency : ack pulses in the 81st cycle after the accepting edge; csb stays high >= 3 cycles between reads.
// Backpressure: requests are level-held until their ack; none are accepted while a read is in flight or in the gap.
// Ports   : clk/reset (async, active high); i_req0/i_addr0 renderer, i_req1/i_addr1 host;
//           o_ack0/o_ack1 completion pulses with o_rdata; o_busy; o_tex_* flash pins, i_tex_in[1] = MISO.
module tex_flash_sched #(
    parameter logic [7:0] READ_CMD = 8'h03
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req0,
    input  logic [23:0] i_addr0,
    input  logic        i_req1,
    input  logic [23:0] i_addr1,
    output logic        o_ack0,
    output logic        o_ack1,
    output logic [7:0]  o_rdata,
    output logic        o_busy,
    output logic        o_tex_csb,
    output logic        o_tex_sclk,
    output logic        o_tex_out0,
    output logic        o_tex_oeb0,
    input  logic [3:0]  i_tex_in
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [1:0]  state;
    logic [5:0]  bit_cnt;   // 0..39: 8 opcode, 24 address, 8 data bits
    logic        phase;     // 0 = sclk low phase, 1 = sclk high phase
    logic [31:0] tx_sr;     // remaining opcode/address bits, next bit at [31]
    logic [6:0]  rx_sr;     // first seven data bits; the eighth joins on the final edge
    logic        cur_id;
    logic        last_id;   // last-served requester, the other one wins a tie
    logic        grant1;
    logic        miso;

    // Only io1 carries read data; the other pads are inputs we ignore.
    logic unused_tex_in;
    assign unused_tex_in = ^{i_tex_in[3:2], i_tex_in[0]};
    assign miso = i_tex_in[1];

    always_comb begin
        grant1 = i_req1 && (!i_req0 || !last_id);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            bit_cnt    <= 6'd0;
            phase      <= 1'b0;
            tx_sr      <= 32'd0;
            rx_sr      <= 7'd0;
            cur_id     <= 1'b0;
            last_id    <= 1'b1;
            o_ack0     <= 1'b0;
            o_ack1     <= 1'b0;
            o_rdata    <= 8'd0;
            o_busy     <= 1'b0;
            o_tex_csb  <= 1'b1;
            o_tex_sclk <= 1'b0;
            o_tex_out0 <= 1'b0;
            o_tex_oeb0 <= 1'b1;
        end else begin
            o_ack0 <= 1'b0;
            o_ack1 <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_req0 || i_req1) begin
                        state      <= S_SHIFT;
                        o_busy     <= 1'b1;
                        o_tex_csb  <= 1'b0;
                        o_tex_sclk <= 1'b0;
                        o_tex_oeb0 <= 1'b0;
                        o_tex_out0 <= READ_CMD[7];
                        tx_sr      <= {READ_CMD[6:0], (grant1 ? i_addr1 : i_addr0), 1'b0};
                        bit_cnt    <= 6'd0;
                        phase      <= 1'b0;
                        cur_id     <= grant1;
                        last_id    <= grant1;
                    end
                end
                S_SHIFT: begin
                    if (!phase) begin
                        o_tex_sclk <= 1'b1;
                        phase      <= 1'b1;
                    end else begin
                        // Edge ending the high phase: data bits are sampled here.
                        o_tex_sclk <= 1'b0;
                        phase      <= 1'b0;
                        if (bit_cnt >= 6'd32) begin
                            rx_sr <= {rx_sr[5:0], miso};
                        end
                        if (bit_cnt == 6'd39) begin
                            state      <= S_DONE;
                            o_tex_csb  <= 1'b1;
                            o_tex_oeb0 <= 1'b1;
                            o_tex_out0 <= 1'b0;
                            o_rdata    <= {rx_sr, miso};
                            o_ack0     <= !cur_id;
                            o_ack1     <= cur_id;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                            if (bit_cnt < 6'd31) begin
                                o_tex_out0 <= tx_sr[31];
                                tx_sr      <= {tx_sr[30:0], 1'b0};
                            end else begin
                                // Data phase: release io0 so the flash can drive.
                                o_tex_out0 <= 1'b0;
                                o_tex_oeb0 <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state <= S_GAP;
                end
                S_GAP: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tex_flash_sched.sv
// Purpose : directed bench for tex_flash_sched with a behavioural SPI flash returning a chosen byte.
// Latency : each read is checked for an ack in the 81st cycle after acceptance.
// Backpressure: requesters hold their request until ack, or drop it deliberately in corner cases.
module tb_tex_flash_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req0, i_req1;
    logic [23:0] i_addr0, i_addr1;
    logic        o_ack0, o_ack1;
    logic [7:0]  o_rdata;
    logic        o_busy;
    logic        o_tex_csb, o_tex_sclk, o_tex_out0, o_tex_oeb0;
    logic [3:0]  i_tex_in;

    int n_chk = 0;
    int n_err = 0;

    tex_flash_sched dut (
        .clk        (clk),
        .reset      (reset),
        .i_req0     (i_req0),
        .i_addr0    (i_addr0),
        .i_req1     (i_req1),
        .i_addr1    (i_addr1),
        .o_ack0     (o_ack0),
        .o_ack1     (o_ack1),
        .o_rdata    (o_rdata),
        .o_busy     (o_busy),
        .o_tex_csb  (o_tex_csb),
        .o_tex_sclk (o_tex_sclk),
        .o_tex_out0 (o_tex_out0),
        .o_tex_oeb0 (o_tex_oeb0),
        .i_tex_in   (i_tex_in)
    );

    always #5 clk = ~clk;

    // Flash model and pin monitor, restarted at every chip-select assertion.
    logic [7:0]  flash_byte = 8'h00;
    logic        miso = 1'b0;
    int          n_rise = 0;
    logic [31:0] cap = 32'd0;
    int          dcyc = 0, oeb_cnt = 0, z_cnt = 0;

    assign i_tex_in = {2'b00, miso, 1'b0};

    always @(negedge o_tex_csb) begin
        n_rise  = 0;
        cap     = 32'd0;
        dcyc    = 0;
        oeb_cnt = 0;
        z_cnt   = 0;
        miso    = 1'b0;
    end

    always @(posedge o_tex_sclk) begin
        if (!o_tex_csb) begin
            if (n_rise < 32) cap = {cap[30:0], o_tex_out0};
            n_rise = n_rise + 1;
            // After the 33rd..40th rising edges present data bits 7..0.
            if (n_rise >= 33 && n_rise <= 40) miso = flash_byte[40 - n_rise];
        end
    end

    always @(negedge clk) begin
        if (!o_tex_csb && (n_rise > 32 || (n_rise == 32 && !o_tex_sclk))) begin
            dcyc = dcyc + 1;
            if (o_tex_oeb0)  oeb_cnt = oeb_cnt + 1;
            if (!o_tex_out0) z_cnt   = z_cnt + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Runs one read whose request(s) are already driven. pre = csb-high cycles
    // seen before acceptance. The granted request is released on its ack.
    task automatic txn(input string nm, input logic exp_id, input logic [7:0] fb,
                       input logic [31:0] exp_cap, input int drop_cyc,
                       input logic hold0, output int pre);
        int  cyc;
        logic got;
        flash_byte = fb;
        pre = 0;
        @(negedge clk);
        while (o_tex_csb && pre < 200) begin
            pre++;
            @(negedge clk);
        end
        if (o_tex_csb) begin
            chk({nm, " accept timeout"}, 32'd0, 32'd1);
            return;
        end
        cyc = 1;
        got = 1'b0;
        while (cyc < 100 && !got) begin
            if (o_ack0 || o_ack1) got = 1'b1;
            else begin
                if (cyc == drop_cyc) i_req1 = 1'b0;
                @(negedge clk);
                cyc++;
            end
        end
        chk({nm, " ack seen"}, {31'd0, got}, 32'd1);
        chk({nm, " ack cycle"}, cyc, 32'd81);
        chk({nm, " ack id"}, {30'd0, o_ack1, o_ack0}, exp_id ? 32'd2 : 32'd1);
        chk({nm, " rdata"}, {24'd0, o_rdata}, {24'd0, fb});
        chk({nm, " cmd+addr"}, cap, exp_cap);
        chk({nm, " data cycles"}, dcyc, 32'd16);
        chk({nm, " oeb0 high in data"}, oeb_cnt, 32'd16);
        chk({nm, " out0 low in data"}, z_cnt, 32'd16);
        if (exp_id) i_req1 = 1'b0;
        else if (!hold0) i_req0 = 1'b0;
        @(negedge clk);
        chk({nm, " gap ack low"}, {30'd0, o_ack1, o_ack0}, 32'd0);
        chk({nm, " gap csb/busy"}, {30'd0, o_tex_csb, o_busy}, 32'd3);
        chk({nm, " rdata held"}, {24'd0, o_rdata}, {24'd0, fb});
        @(negedge clk);
        chk({nm, " idle csb/busy"}, {30'd0, o_tex_csb, o_busy}, 32'd2);
    endtask

    typedef struct {
        logic        r0;
        logic        r1;
        logic [23:0] addr;
        logic [7:0]  fb;
        logic        exp_id;
        logic [31:0] exp_cap;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int pre;
        int cyc;
        int acks;
        int lows;

        vecs[0] = '{1'b1, 1'b0, 24'h012345, 8'hA5, 1'b0, 32'h03012345};
        vecs[1] = '{1'b0, 1'b1, 24'hABCDEF, 8'hFF, 1'b1, 32'h03ABCDEF};
        vecs[2] = '{1'b1, 1'b0, 24'h800001, 8'h00, 1'b0, 32'h03800001};
        vecs[3] = '{1'b0, 1'b1, 24'hFEDCBA, 8'h3C, 1'b1, 32'h03FEDCBA};

        reset = 1'b1;
        i_req0 = 1'b0; i_req1 = 1'b0;
        i_addr0 = 24'd0; i_addr1 = 24'd0;
        repeat (3) @(negedge clk);
        chk("reset pins csb,sclk,out0,oeb0", {28'd0, o_tex_csb, o_tex_sclk, o_tex_out0, o_tex_oeb0}, 32'h9);
        chk("reset ack/busy", {29'd0, o_ack1, o_ack0, o_busy}, 32'd0);
        chk("reset rdata", {24'd0, o_rdata}, 32'd0);
        reset = 1'b0;

        // Single-requester reads from the table.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            i_req0 = vecs[i].r0;
            i_req1 = vecs[i].r1;
            i_addr0 = vecs[i].addr;
            i_addr1 = vecs[i].addr;
            txn($sformatf("vec%0d", i), vecs[i].exp_id, vecs[i].fb, vecs[i].exp_cap, -1, 1'b0, pre);
        end

        // Tie after reset, then req0 held while req1 is pulsed: grants 0,1,0,1,
        // each next accept exactly 3 csb-high cycles after the previous ack.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        i_addr0 = 24'h111111;
        i_addr1 = 24'h222222;
        i_req0 = 1'b1;
        i_req1 = 1'b1;
        txn("rr0", 1'b0, 8'hC3, 32'h03111111, -1, 1'b1, pre);
        txn("rr1", 1'b1, 8'h5A, 32'h03222222, -1, 1'b1, pre);
        chk("rr1 accept gap", pre, 32'd0);
        i_req1 = 1'b1;
        txn("rr2", 1'b0, 8'h81, 32'h03111111, -1, 1'b1, pre);
        chk("rr2 accept gap", pre, 32'd0);
        txn("rr3", 1'b1, 8'h7E, 32'h03222222, -1, 1'b1, pre);
        chk("rr3 accept gap", pre, 32'd0);
        i_req0 = 1'b0;

        // Reset in the low phase of bit 20, then a clean req1 read.
        @(negedge clk);
        i_addr0 = 24'h0F0F0F;
        i_req0 = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (o_tex_csb && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        chk("rst-mid started", {31'd0, o_tex_csb}, 32'd0);
        for (int c = 1; c < 41; c++) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst-mid async pins", {28'd0, o_tex_csb, o_tex_sclk, o_tex_out0, o_tex_oeb0}, 32'h9);
        chk("rst-mid busy/rdata", {23'd0, o_busy, o_rdata}, 32'd0);
        i_req0 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        acks = 0;
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (o_ack0 || o_ack1) acks++;
            if (!o_tex_csb) lows++;
        end
        chk("rst-mid no ack", acks, 32'd0);
        chk("rst-mid csb stays high", lows, 32'd0);
        i_addr1 = 24'h5A5A5A;
        i_req1 = 1'b1;
        txn("post-rst", 1'b1, 8'h96, 32'h035A5A5A, -1, 1'b0, pre);

        // req1 dropped at bit 10: the read still completes.
        @(negedge clk);
        i_addr1 = 24'h00FF00;
        i_req1 = 1'b1;
        txn("drop", 1'b1, 8'h24, 32'h0300FF00, 21, 1'b0, pre);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
